// File: rtl/result_scorer_if.sv
// rtl/result_scorer_if.sv - image hand-off and prediction report bundle for result_scorer
interface result_scorer_if #(
    parameter int N_CLASSES = 10,
    parameter int WIDTH     = 32
);
    logic                                done_in;
    logic [N_CLASSES-1:0][WIDTH-1:0]     result;
    logic [7:0]                          label_in;
    logic [3:0]                          pred;
    logic                                pred_valid;
    logic                                correct;
    logic                                bad_label;

    modport master (
        output done_in,
        output result,
        output label_in,
        input  pred,
        input  pred_valid,
        input  correct,
        input  bad_label
    );

    modport slave (
        input  done_in,
        input  result,
        input  label_in,
        output pred,
        output pred_valid,
        output correct,
        output bad_label
    );
endinterface

// File: rtl/result_scorer.sv
// rtl/result_scorer.sv - sequential argmax of class scores, label compare and accuracy counters
module result_scorer #(
    parameter int N_CLASSES = 10,
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    result_scorer_if.slave    bus,
    input  logic              clear_stats,
    output logic              busy,
    output logic [CNT_W-1:0]  total_cnt,
    output logic [CNT_W-1:0]  correct_cnt,
    output logic              overrun
);
    localparam logic [7:0] NC8     = 8'(N_CLASSES);
    localparam logic [3:0] LAST    = 4'(N_CLASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_t;

    state_t                          r_state;
    logic                            r_done_q;
    logic [N_CLASSES-1:0][WIDTH-1:0] r_buf;
    logic [7:0]                      r_label;
    logic signed [WIDTH-1:0]         r_best_val;
    logic [3:0]                      r_best_idx;
    logic [3:0]                      r_idx;
    logic [3:0]                      r_pred;
    logic                            r_pred_valid;
    logic                            r_correct;
    logic                            r_bad_label;
    logic                            r_busy;
    logic                            r_overrun;
    logic [CNT_W-1:0]                r_total_cnt;
    logic [CNT_W-1:0]                r_correct_cnt;

    logic                            w_start;
    logic signed [WIDTH-1:0]         w_cand;
    logic                            w_take;
    logic [3:0]                      w_win_idx;
    logic signed [WIDTH-1:0]         w_win_val;
    logic                            w_label_ok;
    logic                            w_match;

    assign w_start    = bus.done_in & ~r_done_q;
    assign w_cand     = $signed(r_buf[r_idx]);
    // Strict compare so that ties keep the lower class index
    assign w_take     = w_cand > r_best_val;
    assign w_win_idx  = w_take ? r_idx  : r_best_idx;
    assign w_win_val  = w_take ? w_cand : r_best_val;
    assign w_label_ok = r_label < NC8;
    assign w_match    = (r_label == {4'b0000, w_win_idx});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            // Track done_in through reset so a level held across reset is not an edge
            r_done_q      <= bus.done_in;
            r_buf         <= '0;
            r_label       <= '0;
            r_best_val    <= '0;
            r_best_idx    <= '0;
            r_idx         <= '0;
            r_pred        <= '0;
            r_pred_valid  <= 1'b0;
            r_correct     <= 1'b0;
            r_bad_label   <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_total_cnt   <= '0;
            r_correct_cnt <= '0;
        end else begin
            r_done_q     <= bus.done_in;
            r_pred_valid <= 1'b0;

            if (clear_stats) begin
                r_overrun <= 1'b0;
            end else if (w_start && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_buf      <= bus.result;
                        r_label    <= bus.label_in;
                        r_best_val <= $signed(bus.result[0]);
                        r_best_idx <= 4'd0;
                        r_idx      <= 4'd1;
                        r_busy     <= 1'b1;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    r_best_val <= w_win_val;
                    r_best_idx <= w_win_idx;
                    r_idx      <= r_idx + 4'd1;
                    if (r_idx == LAST) begin
                        r_pred       <= w_win_idx;
                        r_pred_valid <= 1'b1;
                        r_correct    <= w_match & w_label_ok;
                        r_bad_label  <= ~w_label_ok;
                        r_state      <= REPORT;
                    end
                end
                REPORT: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase

            // Clear beats the REPORT-cycle increment; the reported image goes uncounted
            if (clear_stats) begin
                r_total_cnt   <= '0;
                r_correct_cnt <= '0;
            end else if (r_state == REPORT) begin
                if (r_total_cnt != CNT_MAX) begin
                    r_total_cnt <= r_total_cnt + 1'b1;
                end
                if (r_correct && (r_correct_cnt != CNT_MAX)) begin
                    r_correct_cnt <= r_correct_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.pred       = r_pred;
    assign bus.pred_valid = r_pred_valid;
    assign bus.correct    = r_correct;
    assign bus.bad_label  = r_bad_label;
    assign busy           = r_busy;
    assign total_cnt      = r_total_cnt;
    assign correct_cnt    = r_correct_cnt;
    assign overrun        = r_overrun;
endmodule
